// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder: op select codes, ALU_op classes
// and the funct7/funct3 patterns recognised for R-type instructions.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam logic [1:0] ALU_OP_LDST  = 2'b00;
  localparam logic [1:0] ALU_OP_BR    = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_DIV     = 3'b100;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of (ALU_op, {funct7,funct3}) into an ALU op select.
// MUL/DIV decoding is present only when ALU_CTRL_MULDIV_EN is defined.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [9:0] instruction,
  output logic [2:0] op_next,
  output logic       illegal_next
);

  always_comb begin
    // Anything that fails to match, including X/Z inputs, lands on NOP/illegal.
    op_next      = OP_NOP;
    illegal_next = 1'b1;
    case (alu_op)
      ALU_OP_LDST: begin
        op_next      = OP_ADD;
        illegal_next = 1'b0;
      end
      ALU_OP_BR: begin
        op_next      = OP_SUB;
        illegal_next = 1'b0;
      end
      ALU_OP_RTYPE: begin
        case (instruction)
          {F7_BASE, F3_ADD_SUB}: begin
            op_next      = OP_ADD;
            illegal_next = 1'b0;
          end
          {F7_BASE, F3_AND}: begin
            op_next      = OP_AND;
            illegal_next = 1'b0;
          end
          {F7_BASE, F3_OR}: begin
            op_next      = OP_OR;
            illegal_next = 1'b0;
          end
          {F7_ALT, F3_ADD_SUB}: begin
            op_next      = OP_SUB;
            illegal_next = 1'b0;
          end
`ifdef ALU_CTRL_MULDIV_EN
          {F7_MULDIV, F3_ADD_SUB}: begin
            op_next      = OP_MUL;
            illegal_next = 1'b0;
          end
          {F7_MULDIV, F3_DIV}: begin
            op_next      = OP_DIV;
            illegal_next = 1'b0;
          end
`else
          {F7_MULDIV, F3_ADD_SUB}, {F7_MULDIV, F3_DIV}: begin
            op_next      = OP_NOP;
            illegal_next = 1'b1;
          end
`endif
          default: begin
            op_next      = OP_NOP;
            illegal_next = 1'b1;
          end
        endcase
      end
      default: begin
        op_next      = OP_NOP;
        illegal_next = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// ALU control: registered decode of ALU_op class and R-type funct fields.
// Build option ALU_CTRL_MULDIV_EN enables the MUL/DIV encodings.
module alu_control
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ALU_op,
  input  logic [9:0] instruction,
  output logic [2:0] ALU_out,
  output logic       illegal
);

  logic [2:0] op_next;
  logic       illegal_next;

  alu_ctrl_decode u_decode (
    .alu_op       (ALU_op),
    .instruction  (instruction),
    .op_next      (op_next),
    .illegal_next (illegal_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ALU_out <= OP_NOP;
      illegal <= 1'b0;
    end else begin
      ALU_out <= op_next;
      illegal <= illegal_next;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// Scoreboard bench for alu_control: driver pushes expected results from a
// table-driven reference model, a monitor pops and compares each cycle.
module tb_alu_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ALU_op;
  logic [9:0] instruction;
  logic [2:0] ALU_out;
  logic       illegal;

  always #5 clk = ~clk;

  alu_control dut (
    .clk         (clk),
    .reset       (reset),
    .ALU_op      (ALU_op),
    .instruction (instruction),
    .ALU_out     (ALU_out),
    .illegal     (illegal)
  );

  typedef struct {
    logic [2:0] op;
    logic       ill;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: the set of legal R-type instruction words and their results.
  logic [2:0] rtype_map [int];
  logic [9:0] picks [10];

  function automatic void model(input logic r, input logic [1:0] o,
                                input logic [9:0] i,
                                output logic [2:0] eo, output logic ei);
    if (r) begin
      eo = 3'd7; ei = 1'b0;
    end else if (o == 2'd0) begin
      eo = 3'd2; ei = 1'b0;
    end else if (o == 2'd1) begin
      eo = 3'd6; ei = 1'b0;
    end else if (o == 2'd2 && rtype_map.exists(int'(i))) begin
      eo = rtype_map[int'(i)]; ei = 1'b0;
    end else begin
      eo = 3'd7; ei = 1'b1;
    end
  endfunction

  task automatic apply(input logic r, input logic [1:0] o,
                       input logic [9:0] i, input string name);
    exp_t e;
    @(negedge clk);
    reset       = r;
    ALU_op      = o;
    instruction = i;
    model(r, o, i, e.op, e.ill);
    e.name = name;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      cur = q.pop_front();
      vectors++;
      if (ALU_out !== cur.op || illegal !== cur.ill) begin
        miscompares++;
        $display("FAIL %s: got ALU_out=%b illegal=%b, expected ALU_out=%b illegal=%b",
                 cur.name, ALU_out, illegal, cur.op, cur.ill);
      end else begin
        $display("ok   %s: ALU_out=%b illegal=%b", cur.name, ALU_out, illegal);
      end
    end
  end

  initial begin
    logic       r;
    logic [1:0] o;
    logic [9:0] i;

    rtype_map[10'h000] = 3'd2;   // ADD
    rtype_map[10'h007] = 3'd0;   // AND
    rtype_map[10'h006] = 3'd1;   // OR
    rtype_map[10'h100] = 3'd6;   // SUB
`ifdef ALU_CTRL_MULDIV_EN
    rtype_map[10'h008] = 3'd3;   // MUL
    rtype_map[10'h00C] = 3'd4;   // DIV
`endif
    picks[0] = 10'h000; picks[1] = 10'h007; picks[2] = 10'h006;
    picks[3] = 10'h100; picks[4] = 10'h008; picks[5] = 10'h00C;
    picks[6] = 10'h3FF; picks[7] = 10'h002; picks[8] = 10'h101;
    picks[9] = 10'h00F;

    reset = 1'b1; ALU_op = 2'b10; instruction = 10'h007;

    apply(1'b1, 2'b10, 10'h007, "reset0");
    apply(1'b1, 2'b11, 10'h3FF, "reset1");
    apply(1'b0, 2'b10, 10'h000, "r_add");
    apply(1'b0, 2'b10, 10'h100, "r_sub");
    apply(1'b0, 2'b10, 10'h007, "r_and");
    apply(1'b0, 2'b10, 10'h006, "r_or");
    apply(1'b0, 2'b10, 10'h008, "r_mul");
    apply(1'b0, 2'b10, 10'h00C, "r_div");
    apply(1'b0, 2'b10, 10'h3FF, "r_all_ones");
    apply(1'b0, 2'b00, 10'h3FF, "ldst_ones");
    apply(1'b0, 2'b00, 10'h002, "ldst_002");
    apply(1'b0, 2'b01, 10'h3FF, "br_ones");
    apply(1'b0, 2'b01, 10'h000, "br_zero");
    apply(1'b0, 2'b11, 10'h000, "none");
    apply(1'b0, 2'b10, 10'h007, "pre_reset_and");
    apply(1'b1, 2'b10, 10'h007, "mid_reset_and");
    apply(1'b0, 2'b10, 10'h007, "post_reset_and");

    for (int n = 0; n < 200; n++) begin
      r = ($urandom_range(0, 19) == 0);
      o = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) i = picks[$urandom_range(0, 9)];
      else                           i = 10'($urandom);
      apply(r, o, i, $sformatf("rand%0d r=%b op=%b ins=%b", n, r, o, i));
    end

    @(negedge clk);
    reset = 1'b0; ALU_op = 2'b11; instruction = 10'h000;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending results, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
